// File: rtl/bcd_countdown_timer.sv
// MM:SS BCD countdown timer with load/start/pause control and a one-cycle done
// pulse when the count reaches 00:00. All outputs come from registered state.
module bcd_countdown_timer (
  input  logic       clk,
  input  logic       rst,
  input  logic       tick,
  input  logic       load,
  input  logic [7:0] load_min,
  input  logic [7:0] load_sec,
  input  logic       start,
  input  logic       pause,
  output logic [7:0] min,
  output logic [7:0] sec,
  output logic       running,
  output logic       expired,
  output logic       done
);

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    RUN     = 2'd1,
    PAUSED  = 2'd2,
    EXPIRED = 2'd3
  } state_t;

  state_t      state_q, state_d;
  logic [15:0] cnt_q, cnt_d;
  logic [15:0] cnt_dec;
  logic        done_q, done_d;

  // Clamp one BCD byte: tens to at most 5, ones to at most 9.
  function automatic logic [7:0] clamp_bcd(input logic [7:0] v);
    logic [3:0] tens, ones;
    tens = (v[7:4] > 4'd5) ? 4'd5 : v[7:4];
    ones = (v[3:0] > 4'd9) ? 4'd9 : v[3:0];
    return {tens, ones};
  endfunction

  // One-second BCD decrement; never called on 00:00, so min tens cannot underflow.
  function automatic logic [15:0] dec_bcd(input logic [15:0] v);
    logic [3:0] mt, mo, st, so;
    logic       borrow;
    {mt, mo, st, so} = v;
    borrow = (so == 4'd0);
    so     = borrow ? 4'd9 : so - 4'd1;
    if (borrow) begin
      borrow = (st == 4'd0);
      st     = borrow ? 4'd5 : st - 4'd1;
      if (borrow) begin
        borrow = (mo == 4'd0);
        mo     = borrow ? 4'd9 : mo - 4'd1;
        if (borrow) mt = mt - 4'd1;
      end
    end
    return {mt, mo, st, so};
  endfunction

  assign cnt_dec = dec_bcd(cnt_q);

  always_comb begin
    // NOTE: every signal gets a default before any branch so no latch is inferred.
    state_d = state_q;
    cnt_d   = cnt_q;
    done_d  = 1'b0;
    if (load) begin
      cnt_d   = {clamp_bcd(load_min), clamp_bcd(load_sec)};
      state_d = IDLE;
    end else begin
      unique case (state_q)
        IDLE, PAUSED: begin
          if (start) begin
            if (cnt_q == 16'h0000) begin
              state_d = EXPIRED;
              done_d  = 1'b1;
            end else begin
              state_d = RUN;
            end
          end
        end
        RUN: begin
          if (pause) begin
            state_d = PAUSED;
          end else if (tick) begin
            cnt_d = cnt_dec;
            if (cnt_dec == 16'h0000) begin
              state_d = EXPIRED;
              done_d  = 1'b1;
            end
          end
        end
        EXPIRED: ;
        default: state_d = IDLE;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    // NOTE: sequential state uses non-blocking assignments so all registers update together.
    if (rst) begin
      state_q <= IDLE;
      cnt_q   <= 16'h0000;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      done_q  <= done_d;
    end
  end

  assign min     = cnt_q[15:8];
  assign sec     = cnt_q[7:0];
  assign running = (state_q == RUN);
  assign expired = (state_q == EXPIRED);
  assign done    = done_q;

endmodule

// File: tb/tb_bcd_countdown_timer.sv
// Directed self-checking bench for bcd_countdown_timer; inputs change and
// outputs are sampled 1 ns after each rising edge.
module tb_bcd_countdown_timer;

  logic       clk = 1'b0;
  logic       rst = 1'b0;
  logic       tick = 1'b0;
  logic       load = 1'b0;
  logic [7:0] load_min = 8'h00;
  logic [7:0] load_sec = 8'h00;
  logic       start = 1'b0;
  logic       pause = 1'b0;
  logic [7:0] min, sec;
  logic       running, expired, done;

  int tests  = 0;
  int failed = 0;

  bcd_countdown_timer dut (
    .clk      (clk),
    .rst      (rst),
    .tick     (tick),
    .load     (load),
    .load_min (load_min),
    .load_sec (load_sec),
    .start    (start),
    .pause    (pause),
    .min      (min),
    .sec      (sec),
    .running  (running),
    .expired  (expired),
    .done     (done)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [15:0] observed, input logic [15:0] expected);
    tests++;
    assert (observed === expected) else begin
      failed++;
      $error("FAIL %s: observed %h expected %h", tag, observed, expected);
    end
  endtask

  // {min, sec} and {running, expired, done} as compact comparison words.
  function automatic logic [15:0] val();
    return {min, sec};
  endfunction
  function automatic logic [15:0] flags();
    return {13'd0, running, expired, done};
  endfunction

  function automatic logic [15:0] to_bcd(input int secs);
    int m, s;
    m = secs / 60;
    s = secs % 60;
    return {4'(m / 10), 4'(m % 10), 4'(s / 10), 4'(s % 10)};
  endfunction

  task automatic cycle();
    @(posedge clk);
    #1;
  endtask

  task automatic do_load(input logic [7:0] m, input logic [7:0] s);
    load = 1'b1; load_min = m; load_sec = s;
    cycle();
    load = 1'b0;
  endtask

  task automatic do_start();
    start = 1'b1;
    cycle();
    start = 1'b0;
  endtask

  task automatic do_ticks(input int n);
    tick = 1'b1;
    repeat (n) cycle();
    tick = 1'b0;
  endtask

  initial begin
    // Reset state
    rst = 1'b1;
    cycle(); cycle();
    rst = 1'b0;
    check("reset_val", val(), 16'h0000);
    check("reset_flags", flags(), 16'h0000);

    // 01:00 full countdown
    do_load(8'h01, 8'h00);
    check("load_0100", val(), 16'h0100);
    check("load_flags", flags(), 16'h0000);
    do_start();
    check("start_running", flags(), 16'h0004);
    tick = 1'b1;
    for (int i = 1; i < 60; i++) begin
      cycle();
      check($sformatf("cd_%0d", i), val(), to_bcd(60 - i));
      check($sformatf("cd_flags_%0d", i), flags(), 16'h0004);
    end
    cycle();
    check("cd_zero", val(), 16'h0000);
    check("cd_done", flags(), 16'h0003);
    cycle();
    check("expired_hold_val", val(), 16'h0000);
    check("done_one_cycle", flags(), 16'h0002);
    tick = 1'b0;
    start = 1'b1; pause = 1'b1;
    cycle();
    start = 1'b0; pause = 1'b0;
    check("expired_ignores_ctl", flags(), 16'h0002);

    // Borrow chains
    do_load(8'h10, 8'h00);
    check("load_exits_expired", flags(), 16'h0000);
    do_start(); do_ticks(1);
    check("borrow_1000", val(), 16'h0959);
    do_load(8'h00, 8'h10);
    do_start(); do_ticks(1);
    check("borrow_0010", val(), 16'h0009);
    do_load(8'h59, 8'h59);
    do_start(); do_ticks(1);
    check("dec_5959", val(), 16'h5958);

    // Pause / resume
    do_load(8'h00, 8'h05);
    do_start(); do_ticks(2);
    check("pr_run", val(), 16'h0003);
    pause = 1'b1; tick = 1'b1;
    cycle();
    pause = 1'b0; tick = 1'b0;
    check("pause_drops_tick", val(), 16'h0003);
    check("paused_flags", flags(), 16'h0000);
    do_ticks(3);
    check("paused_hold", val(), 16'h0003);
    do_start();
    check("resume_flags", flags(), 16'h0004);
    do_ticks(2);
    check("resume_dec", val(), 16'h0001);
    tick = 1'b1;
    cycle();
    check("resume_zero", val(), 16'h0000);
    check("resume_done", flags(), 16'h0003);
    tick = 1'b0;

    // Simultaneous events
    do_load(8'h00, 8'h02);
    start = 1'b1; tick = 1'b1;
    cycle();
    start = 1'b0; tick = 1'b0;
    check("start_tick_val", val(), 16'h0002);
    check("start_tick_flags", flags(), 16'h0004);
    start = 1'b1; pause = 1'b1;
    cycle();
    start = 1'b0; pause = 1'b0;
    check("pause_wins_in_run", flags(), 16'h0000);
    start = 1'b1; pause = 1'b1;
    cycle();
    start = 1'b0; pause = 1'b0;
    check("start_wins_in_paused", flags(), 16'h0004);
    load = 1'b1; load_min = 8'h00; load_sec = 8'h30; tick = 1'b1;
    cycle();
    load = 1'b0; tick = 1'b0;
    check("load_tick_val", val(), 16'h0030);
    check("load_tick_idle", flags(), 16'h0000);
    do_ticks(2);
    check("idle_ignores_tick", val(), 16'h0030);

    // Zero start and clamping
    do_load(8'h00, 8'h00);
    do_start();
    check("zero_start_done", flags(), 16'h0003);
    cycle();
    check("zero_start_after", flags(), 16'h0002);
    do_load(8'h7A, 8'h9F);
    check("clamp", val(), 16'h5959);
    do_load(8'h3C, 8'h6B);
    check("clamp_mixed", val(), 16'h3959);

    // Reset mid-run
    do_load(8'h00, 8'h10);
    do_start(); do_ticks(3);
    check("pre_reset", val(), 16'h0007);
    rst = 1'b1; tick = 1'b1;
    cycle();
    rst = 1'b0; tick = 1'b0;
    check("reset_run_val", val(), 16'h0000);
    check("reset_run_flags", flags(), 16'h0000);
    do_start();
    check("post_reset_start", flags(), 16'h0003);

    $display("[TB] %0d tests run, %0d failed", tests, failed);
    $finish;
  end

endmodule
